// File: rtl/timer_sched_if.sv
// rtl/timer_sched_if.sv - arm/cancel/ack request and timer status bundle for timer_sched
interface timer_sched_if #(
    parameter int WIDTH = 36,
    parameter int NCH   = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             arm_valid;
    logic             arm_ready;
    logic [CW-1:0]    arm_ch;
    logic [WIDTH-1:0] arm_delay;
    logic             cancel_valid;
    logic [CW-1:0]    cancel_ch;
    logic             ack_valid;
    logic [CW-1:0]    ack_ch;
    logic [WIDTH-1:0] now;
    logic [NCH-1:0]   armed;
    logic [NCH-1:0]   fire;
    logic [NCH-1:0]   pend;
    logic             irq;

    modport master (
        output arm_valid, arm_ch, arm_delay, cancel_valid, cancel_ch, ack_valid, ack_ch,
        input  arm_ready, now, armed, fire, pend, irq
    );

    modport slave (
        input  arm_valid, arm_ch, arm_delay, cancel_valid, cancel_ch, ack_valid, ack_ch,
        output arm_ready, now, armed, fire, pend, irq
    );
endinterface

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - free-running time base with NCH one-shot deadline channels
module timer_sched #(
    parameter int WIDTH = 36,
    parameter int NCH   = 4
) (
    input logic          clk,
    input logic          reset,
    timer_sched_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0] now_q;
    logic [NCH-1:0]   armed_q;
    logic [NCH-1:0]   pend_q;
    logic             irq_q;
    logic [WIDTH-1:0] deadline_q [NCH];

    logic             arm_accept;
    logic [WIDTH-1:0] eff_delay;
    logic [WIDTH-1:0] new_deadline;
    logic [NCH-1:0]   arm_sel;
    logic [NCH-1:0]   cancel_sel;
    logic [NCH-1:0]   ack_sel;
    logic [NCH-1:0]   fire_c;
    logic [NCH-1:0]   pend_next;

    assign arm_accept   = bus.arm_valid && !reset;
    assign eff_delay    = (bus.arm_delay == '0) ? WIDTH'(1) : bus.arm_delay;
    assign new_deadline = now_q + eff_delay;

    // Index decode never matches an out-of-range channel, so such requests fall through.
    // A cancel only suppresses a fire when no arm to the same channel wins this cycle.
    always_comb begin
        arm_sel    = '0;
        cancel_sel = '0;
        ack_sel    = '0;
        fire_c     = '0;
        for (int i = 0; i < NCH; i++) begin
            arm_sel[i]    = arm_accept && (bus.arm_ch == CW'(i));
            cancel_sel[i] = bus.cancel_valid && (bus.cancel_ch == CW'(i));
            ack_sel[i]    = bus.ack_valid && (bus.ack_ch == CW'(i));
            fire_c[i]     = !reset && armed_q[i] && (deadline_q[i] == now_q)
                            && !(cancel_sel[i] && !arm_sel[i]);
        end
    end

    assign pend_next = (pend_q & ~ack_sel) | fire_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            now_q   <= '0;
            armed_q <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            now_q  <= now_q + WIDTH'(1);
            pend_q <= pend_next;
            irq_q  <= |pend_next;
            for (int i = 0; i < NCH; i++) begin
                if (arm_sel[i]) begin
                    armed_q[i] <= 1'b1;
                end else if (cancel_sel[i] || fire_c[i]) begin
                    armed_q[i] <= 1'b0;
                end
            end
        end
    end

    // Deadlines are only meaningful while armed, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (arm_sel[i]) begin
                deadline_q[i] <= new_deadline;
            end
        end
    end

    assign bus.now       = reset ? '0 : now_q;
    assign bus.arm_ready = !reset;
    assign bus.armed     = reset ? '0 : armed_q;
    assign bus.fire      = fire_c;
    assign bus.pend      = reset ? '0 : pend_q;
    assign bus.irq       = !reset && irq_q;
endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter WIDTH, default 36: width of the free-running time base and of all deadlines/delays.
REQ-002 Parameter NCH, default 4: number of independent timer channels; CW = clog2(NCH), minimum 1.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset reset, synchronous, active-high; clock clk.
REQ-005 now  output  WIDTH  current time-base value.
REQ-006 arm_valid  input  1  request to arm a channel.
REQ-007 arm_ready  output  1  block can accept an arm request.
REQ-008 arm_ch  input  CW  channel index for the arm request.
REQ-009 arm_delay  input  WIDTH  cycles from acceptance to fire.
REQ-010 cancel_valid  input  1  disarm a channel; always accepted.
REQ-011 cancel_ch  input  CW  channel index for the cancel.
REQ-012 ack_valid  input  1  clear the sticky pending flag of a channel.
REQ-013 ack_ch  input  CW  channel index for the ack.
REQ-014 armed  output  NCH  per-channel armed status.
REQ-015 fire  output  NCH  per-channel one-cycle expiry pulse.
REQ-016 pend  output  NCH  per-channel sticky expiry flag.
REQ-017 irq  output  1  OR of pend.

Function
REQ-018 now SHALL increment by 1 every cycle reset is low and wrap from 2^WIDTH-1 to 0.
REQ-019 arm_ready SHALL be 1 in every cycle reset is low and 0 while reset is high; an arm is accepted when arm_valid and arm_ready are both 1.
REQ-020 On acceptance in a cycle where now==C, the channel SHALL store deadline D = (C + max(arm_delay,1)) mod 2^WIDTH and set armed[ch] from the next cycle.
REQ-021 arm_delay==0 SHALL be treated as 1.
REQ-022 fire[ch] SHALL be 1 in exactly the cycle where now==D and armed[ch]==1; armed[ch] SHALL be 0 from the following cycle (one-shot).
REQ-023 Deadline match SHALL be equality only, so deadlines that wrap past 0 fire correctly; the maximum delay is 2^WIDTH-1.
REQ-024 Arming an already-armed channel SHALL replace its deadline; the old deadline SHALL NOT fire.
REQ-025 If arm to ch is accepted in the cycle fire[ch] is 1, the fire SHALL still occur and the new deadline SHALL take effect (armed[ch] stays 1).
REQ-026 cancel SHALL clear armed[cancel_ch] from the next cycle; a cancel in the cycle the channel would fire SHALL suppress that fire and leave pend unchanged.
REQ-027 Cancel and accepted arm to the same channel in the same cycle: the arm SHALL win.
REQ-028 pend[ch] SHALL be set in the cycle after fire[ch] and held until ack_valid with ack_ch==ch; ack and a new fire on the same channel in the same cycle SHALL leave pend set.
REQ-029 Out-of-range channel indices (>= NCH) on arm, cancel or ack SHALL be ignored; out-of-range arms SHALL still be handshaken.
REQ-030 irq SHALL be the registered OR of pend, i.e. asserted the same cycle pend is.
REQ-031 Multiple channels with equal deadlines SHALL fire in the same cycle.

Reset
REQ-032 While reset is high: now=0, armed=0, fire=0, pend=0, irq=0, arm_ready=0; stored deadlines are don't-care.
REQ-033 Reset asserted mid-operation SHALL discard all armed channels and pending flags with no fire pulse afterward.
REQ-034 In the first cycle after reset deasserts, now SHALL read 0 and arm_ready 1.

Verification
REQ-035 Arm ch0 delay=5 when now=10 -> fire[0] pulse exactly at now=15, armed[0] low from now=16, pend[0] and irq high from now=16 until ack.
REQ-036 WIDTH=8: arm ch1 delay=10 at now=250 -> fire[1] at now=4 after wrap.
REQ-037 Arm ch2 delay=20 at now=0, re-arm delay=3 at now=5 -> single fire at now=8, none at now=20.
REQ-038 Arm ch3 delay=4 at now=0, cancel ch3 at now=4 -> no fire, pend[3] stays 0; same with arm+cancel at now=4 -> old fire occurs and new arm takes effect.
REQ-039 ch0 and ch1 both arm with deadline 30 -> fire=0b0011 at now=30; ack ch0 at now=31 while irq stays high via pend[1].
REQ-040 Assert reset with ch0 armed for now=50 at now=40 -> after release now restarts at 0, armed=0, no fire at 50.
